// File: rtl/neuron_driver_if.sv
// neuron_driver_if: host-side input/output streams plus the neuron Run/Ready/X/Y bundle
interface neuron_driver_if #(
    parameter int DATA_WIDTH = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_x1;
    logic signed [DATA_WIDTH-1:0] in_x2;
    logic signed [DATA_WIDTH-1:0] in_x3;
    logic signed [DATA_WIDTH-1:0] in_x4;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_y;
    logic                         err;
    logic                         n_en;
    logic                         n_run;
    logic signed [DATA_WIDTH-1:0] n_x1;
    logic signed [DATA_WIDTH-1:0] n_x2;
    logic signed [DATA_WIDTH-1:0] n_x3;
    logic signed [DATA_WIDTH-1:0] n_x4;
    logic signed [DATA_WIDTH-1:0] n_y;
    logic                         n_ready;

    modport master (
        input  in_valid, in_x1, in_x2, in_x3, in_x4, out_ready, n_y, n_ready,
        output in_ready, out_valid, out_y, err, n_en, n_run, n_x1, n_x2, n_x3, n_x4
    );

    modport slave (
        output in_valid, in_x1, in_x2, in_x3, in_x4, out_ready, n_y, n_ready,
        input  in_ready, out_valid, out_y, err, n_en, n_run, n_x1, n_x2, n_x3, n_x4
    );
endinterface

// File: rtl/neuron_driver.sv
// neuron_driver: runs the neuron's flush pass then the real pass per vector and returns Y, with a per-pass watchdog
module neuron_driver #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 31,
    parameter int CNT_WIDTH  = 8
) (
    input logic          clk,
    input logic          rst,
    neuron_driver_if.master bus
);
    typedef enum logic [2:0] {IDLE, WAIT_BYPASS, WAIT_RESULT, OUTPUT, DRAIN} state_t;

    state_t                       state_q;
    logic                         in_ready_q;
    logic                         out_valid_q;
    logic                         err_q;
    logic                         n_en_q;
    logic                         n_run_q;
    logic                         ready_dly_q;
    logic signed [DATA_WIDTH-1:0] out_y_q;
    logic signed [DATA_WIDTH-1:0] x1_q;
    logic signed [DATA_WIDTH-1:0] x2_q;
    logic signed [DATA_WIDTH-1:0] x3_q;
    logic signed [DATA_WIDTH-1:0] x4_q;
    logic [CNT_WIDTH-1:0]         cnt_q;
    logic                         rise;

    assign rise          = bus.n_ready & ~ready_dly_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.err       = err_q;
    assign bus.n_en      = n_en_q;
    assign bus.n_run     = n_run_q;
    assign bus.n_x1      = x1_q;
    assign bus.n_x2      = x2_q;
    assign bus.n_x3      = x3_q;
    assign bus.n_x4      = x4_q;

    // Sequencer: accept, bypass pass, real pass, hand result out; the counter doubles as watchdog and drain timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            err_q       <= 1'b0;
            n_en_q      <= 1'b0;
            n_run_q     <= 1'b0;
            ready_dly_q <= 1'b0;
            x1_q        <= '0;
            x2_q        <= '0;
            x3_q        <= '0;
            x4_q        <= '0;
            cnt_q       <= '0;
        end else begin
            n_en_q      <= 1'b1;
            ready_dly_q <= bus.n_ready;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        x1_q       <= bus.in_x1;
                        x2_q       <= bus.in_x2;
                        x3_q       <= bus.in_x3;
                        x4_q       <= bus.in_x4;
                        n_run_q    <= 1'b1;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= WAIT_BYPASS;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                WAIT_BYPASS, WAIT_RESULT: begin
                    if (rise) begin
                        cnt_q <= '0;
                        if (state_q == WAIT_BYPASS) begin
                            n_run_q <= 1'b0;
                            state_q <= WAIT_RESULT;
                        end else begin
                            out_y_q     <= bus.n_y;
                            out_valid_q <= 1'b1;
                            state_q     <= OUTPUT;
                        end
                    end else if (cnt_q == CNT_WIDTH'(TIMEOUT)) begin
                        err_q   <= 1'b1;
                        n_run_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                DRAIN: begin
                    if (cnt_q == CNT_WIDTH'(15)) begin
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    n_run_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_driver.sv
// tb_neuron_driver: scoreboard bench with a behavioural XOR_net neuron (flush pass, real pass, stall and stretch modes)
module tb_neuron_driver;
    localparam int TIMEOUT = 31;

    typedef struct {
        logic signed [7:0] y;
        int                acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rises = 0;
    int   n_exp = 0;
    logic ov_prev = 1'b0;
    logic dead = 1'b0;
    logic stretch = 1'b0;
    exp_t q[$];

    neuron_driver_if #(.DATA_WIDTH(8)) ndif ();

    neuron_driver #(.DATA_WIDTH(8), .TIMEOUT(TIMEOUT), .CNT_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ndif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hard-sigmoid neuron: weights 49,32,92,-78, FRAC_BITS=4, y = clamp(8 + s/7, 0, 16)
    function automatic logic signed [7:0] ref_y(input logic signed [7:0] a, b, c, d);
        int s;
        s = (49 * a + 32 * b + 92 * c - 78 * d) >>> 4;
        s = 8 + s / 7;
        if (s < 0) s = 0;
        if (s > 16) s = 16;
        return 8'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Neuron model: FLUSH waits for Run, 6-edge bypass, IDLE samples Run, 6-edge real pass, POST
    localparam int NF = 0, NB = 1, NI = 2, NL = 3, NP = 4;
    int               ns;
    int               ncnt;
    int               hold;
    logic signed [7:0] ny;

    assign ndif.n_ready = (hold != 0);
    assign ndif.n_y     = ny;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ns   <= NF;
            ncnt <= 0;
            hold <= 0;
            ny   <= '0;
        end else begin
            hold <= (hold != 0) ? hold - 1 : 0;
            case (ns)
                NF: if (!dead && ndif.n_run) begin ns <= NB; ncnt <= 1; end
                NB: if (ncnt == 6) begin
                        ns <= NI; hold <= stretch ? 3 : 1; ny <= 8'sh7F;
                    end else ncnt <= ncnt + 1;
                NI: if (ndif.n_run) begin ns <= NL; ncnt <= 1; end else ns <= NF;
                NL: if (ncnt == 6) begin
                        ns <= NP; hold <= 1; ny <= ref_y(ndif.n_x1, ndif.n_x2, ndif.n_x3, ndif.n_x4);
                    end else ncnt <= ncnt + 1;
                default: ns <= ndif.n_run ? NI : NF;
            endcase
        end
    end

    // Monitor: push expectation on acceptance, check latency on out_valid rise, compare Y on handshake
    always @(negedge clk) begin
        if (rst) begin
            ov_prev <= 1'b0;
        end else begin
            if (ndif.in_valid && ndif.in_ready && !dead)
                q.push_back('{y: ref_y(ndif.in_x1, ndif.in_x2, ndif.in_x3, ndif.in_x4), acc: cyc + 1});
            if (ndif.out_valid && !ov_prev) begin
                rises++;
                check("sb_avail", 32'(q.size() > 0), 1);
                if (q.size() > 0) check("latency", cyc - q[0].acc, 15);
            end
            if (ndif.out_valid && ndif.out_ready && q.size() > 0) begin
                check("out_y", ndif.out_y, q[0].y);
                void'(q.pop_front());
            end
            ov_prev <= ndif.out_valid;
        end
    end

    task automatic chk_rst();
        check("rst_in_ready", ndif.in_ready, 0);
        check("rst_out_valid", ndif.out_valid, 0);
        check("rst_out_y", ndif.out_y, 0);
        check("rst_err", ndif.err, 0);
        check("rst_n_en", ndif.n_en, 0);
        check("rst_n_run", ndif.n_run, 0);
        check("rst_n_x", {ndif.n_x1, ndif.n_x2, ndif.n_x3, ndif.n_x4}, 0);
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ndif.in_ready && n < 300);
        check("accept_wait", 32'(n < 300), 1);
        @(posedge clk);
        #1 ndif.in_valid = 1'b0;
    endtask

    task automatic send(input logic signed [7:0] a, b, c, d);
        @(posedge clk);
        #1;
        ndif.in_x1 = a; ndif.in_x2 = b; ndif.in_x3 = c; ndif.in_x4 = d;
        ndif.in_valid = 1'b1;
        wait_accept();
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 300 && (q.size() != 0 || ndif.out_valid); n++) @(negedge clk);
        check("drain_wait", 32'(n < 300), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        ndif.in_valid = 1'b0;
        ndif.in_x1 = '0; ndif.in_x2 = '0; ndif.in_x3 = '0; ndif.in_x4 = '0;
        ndif.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_rst();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("n_en_up", ndif.n_en, 1);
        check("in_ready_up", ndif.in_ready, 1);

        send(16, 0, 0, 0);
        for (n = 0; n < 50; ) begin
            @(negedge clk);
            if (!ndif.n_run) break;
            n++;
        end
        check("n_run_width", n, 8);
        drain();
        n_exp += 1;

        send(0, 0, 0, 0);
        send(0, 0, 16, 0);
        send(0, 0, 0, 16);
        drain();
        n_exp += 3;
        check("err_clean", ndif.err, 0);

        ndif.out_ready = 1'b0;
        send(16, 0, 0, 0);
        for (n = 0; n < 50 && !ndif.out_valid; n++) @(negedge clk);
        check("held_seen", 32'(n < 50), 1);
        @(posedge clk);
        #1;
        ndif.in_x1 = 0; ndif.in_x2 = 0; ndif.in_x3 = 16; ndif.in_x4 = 0;
        ndif.in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("held_valid", ndif.out_valid, 1);
            check("held_y", ndif.out_y, ref_y(16, 0, 0, 0));
            check("held_in_ready", ndif.in_ready, 0);
        end
        @(posedge clk);
        #1 ndif.out_ready = 1'b1;
        wait_accept();
        drain();
        n_exp += 2;

        dead = 1'b1;
        send(16, 0, 0, 0);
        for (n = 0; n < 100 && !ndif.err; n++) begin @(posedge clk); #1; end
        check("err_latency", n, TIMEOUT + 1);
        check("to_n_run", ndif.n_run, 0);
        for (n = 0; n < 100 && !ndif.in_ready; n++) begin
            @(posedge clk);
            #1;
            check("to_no_valid", ndif.out_valid, 0);
        end
        check("drain_len", n, 16);
        dead = 1'b0;
        send(0, 0, 16, 0);
        drain();
        n_exp += 1;
        check("err_sticky", ndif.err, 1);

        send(16, 0, 0, 0);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_rst();
        q.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 check("n_en_again", ndif.n_en, 1);
        send(16, 0, 0, 0);
        drain();
        n_exp += 1;
        check("err_cleared", ndif.err, 0);

        stretch = 1'b1;
        send(0, 16, 0, 0);
        drain();
        n_exp += 1;
        stretch = 1'b0;

        check("ov_pulses", rises, n_exp);
        check("sb_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/neuron_driver.md
Name: neuron_driver

Overview:
- Initiator for the 4-input XOR_net neuron Run/Ready interface.
- Accepts input vectors on a valid/ready stream and drives X1..X4, En and Run to one neuron. It sequences the neuron's mandatory bypass (flush) pass followed by the real pass, and returns the captured Y on a valid/ready output stream.
- Sits between the XOR_net top-level stimulus/host logic and each neuron instance.
- Adds a per-pass timeout watchdog with a sticky error flag.

Parameters:
- DATA_WIDTH, 8, width of neuron inputs and output (signed)
- TIMEOUT, 31, max cycles waited for a Ready rising edge per pass (must be ≥ 8)
- CNT_WIDTH, 8, width of the watchdog counter (2^CNT_WIDTH > TIMEOUT)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  driver can accept a vector
- in_x1..in_x4  in  DATA_WIDTH each  signed input vector
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_y  out  DATA_WIDTH  signed captured neuron Y
- err  out  1  sticky timeout flag
- n_en  out  1  drives neuron En
- n_run  out  1  drives neuron Run
- n_x1..n_x4  out  DATA_WIDTH each  drive neuron X1..X4
- n_y  in  DATA_WIDTH  neuron Y
- n_ready  in  1  neuron Ready

Behaviour:
- All outputs are registered. Reset values: in_ready=0, out_valid=0, out_y=0, err=0, n_en=0, n_run=0, n_x*=0; state=IDLE. The internal ready_d register resets to 0.
- n_en goes to 1 on the first clk edge after rst deasserts and stays 1.
- in_ready=1 only in IDLE while rst is low.
- Ready rise detect: rise = n_ready & ~ready_d, where ready_d is registered every cycle.
- IDLE:
  - On in_valid&in_ready, latch in_x1..4 into n_x1..4 and set n_run=1.
  - Clear the watchdog, set in_ready=0, go to WAIT_BYPASS.
  - n_x* are held stable until the next acceptance.
- WAIT_BYPASS:
  - On rise: set n_run=0 and go to WAIT_RESULT.
  - The neuron samples the old Run=1 in its IDLE state, so it proceeds to LOAD; dropping Run here guarantees the neuron returns to flush after the result.
  - The bypass-pass Y is discarded.
- WAIT_RESULT:
  - On rise: out_y<=n_y, out_valid=1, go to OUTPUT.
- OUTPUT:
  - Hold out_y and out_valid until out_valid&out_ready, then clear out_valid, set in_ready=1, go to IDLE.
  - No new vector is accepted while a result is pending.
- Latency: with an ideal neuron, out_valid rises 15 clk edges after the acceptance edge (1 edge Run launch, 6 bypass, 1 idle, 6 real pass, 1 capture). Throughput is at most 1 vector per 16 cycles with out_ready held high.
- Watchdog:
  - The counter increments each cycle in WAIT_BYPASS/WAIT_RESULT and clears on rise.
  - When the count reaches TIMEOUT: err=1 (sticky until rst), n_run=0, no output is produced, go to DRAIN.
- DRAIN: wait 16 cycles with n_run=0 so the neuron returns to flush, then go to IDLE with in_ready=1.
- A rise seen in IDLE, OUTPUT or DRAIN is ignored.
- A rise coincident with the watchdog reaching TIMEOUT: rise wins, and the count is not a timeout.
- rst mid-operation: immediate return to reset values. The neuron shares rst, so both restart in flush. Any in-flight vector is dropped.
- Undefined state encoding goes to IDLE with n_run=0.

Test Plan:
- Reset, then vector (16,0,0,0) with a 4-input neuron of weights 49,32,92,-78 and FRAC_BITS=4 → out_valid after 15 edges with out_y=15. Exactly one out_valid pulse. n_run high for exactly 8 cycles.
- Vectors (0,0,0,0), (0,0,16,0), (0,0,0,16) back-to-back, out_ready=1 → out_y=8, 16, 0 in order, 16 cycles apart, err=0.
- out_ready=0 for 20 cycles after the first result → out_y and out_valid held, in_ready=0, second in_valid not accepted; release → second result correct.
- Neuron model whose n_ready stays 0 → err=1 after TIMEOUT+1 cycles, n_run=0, no out_valid, in_ready=1 after 16 DRAIN cycles. Next vector with a healthy neuron → correct result, err still 1.
- Assert rst during WAIT_RESULT → all outputs return to reset values immediately. After release, vector (16,0,0,0) → out_y=15 with 15-edge latency.
- n_ready held high 3 cycles in WAIT_BYPASS → a single rise counted, no premature capture.
